crc_frame_checker: RTL and testbench

//  Receive-side partner of the CRC generator. Takes a byte stream framed by sof/eof, in which the

---
 rtl/crc_frame_checker.sv | 168 ++++++++++++++++
 tb/tb_crc_frame_checker.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_checker.sv
// rtl/crc_frame_checker.sv - receive-side CRC-16 frame checker: strips the trailing CRC, forwards payload, reports per-frame result
module crc_frame_checker #(
    parameter logic [15:0] POLY    = 16'h1021,
    parameter logic [15:0] INIT    = 16'hFFFF,
    parameter int          MAX_LEN = 1024,
    parameter int          LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_vld,
    input  logic [7:0]       din,
    input  logic             din_sof,
    input  logic             din_eof,
    output logic             dout_vld,
    output logic [7:0]       dout,
    output logic             dout_last,
    output logic             res_vld,
    output logic             res_ok,
    output logic             res_len_err,
    output logic             res_abort,
    output logic [LEN_W-1:0] res_len,
    output logic [15:0]      res_crc_rx
);
    localparam int CNT_W = $clog2(MAX_LEN + 4);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN + 3);

    typedef enum logic {IDLE, IN_FRAME} state_t;

    state_t           state, state_n;
    logic [15:0]      crc, crc_n;
    logic [7:0]       hold_old, hold_old_n, hold_new, hold_new_n;
    logic [1:0]       hold_cnt, hold_cnt_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic             dout_vld_n, dout_last_n, res_vld_n, res_ok_n, res_len_err_n, res_abort_n;
    logic [7:0]       dout_n;
    logic [LEN_W-1:0] res_len_n;
    logic [15:0]      res_crc_rx_n;

    logic [15:0]      crc_upd;
    logic [CNT_W-1:0] cnt_inc;
    logic             len_err;

    function automatic logic [15:0] crc8_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ POLY;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    // Total byte count minus the two CRC bytes; cnt saturation bounds this at MAX_LEN+1.
    function automatic logic [LEN_W-1:0] payload_len(input logic [CNT_W-1:0] t);
        if (t < CNT_W'(2)) return '0;
        return LEN_W'(t - CNT_W'(2));
    endfunction

    assign crc_upd = crc8_step(crc, din);
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign len_err = (cnt_inc < CNT_W'(3)) || (cnt_inc > CNT_W'(MAX_LEN + 2));

    always_comb begin
        state_n       = state;
        crc_n         = crc;
        hold_old_n    = hold_old;
        hold_new_n    = hold_new;
        hold_cnt_n    = hold_cnt;
        cnt_n         = cnt;
        dout_vld_n    = 1'b0;
        dout_n        = dout;
        dout_last_n   = 1'b0;
        res_vld_n     = 1'b0;
        res_ok_n      = 1'b0;
        res_len_err_n = 1'b0;
        res_abort_n   = 1'b0;
        res_len_n     = res_len;
        res_crc_rx_n  = res_crc_rx;

        if (din_vld) begin
            if (din_sof) begin
                if (state == IN_FRAME) begin
                    res_vld_n   = 1'b1;
                    res_abort_n = 1'b1;
                    res_len_n   = payload_len(cnt);
                end
                if (din_eof) begin
                    if (state == IDLE) begin
                        res_vld_n     = 1'b1;
                        res_len_err_n = 1'b1;
                        res_len_n     = '0;
                        res_crc_rx_n  = {8'h00, din};
                    end
                    state_n    = IDLE;
                    crc_n      = INIT;
                    hold_cnt_n = 2'd0;
                    cnt_n      = '0;
                end else begin
                    state_n    = IN_FRAME;
                    crc_n      = crc8_step(INIT, din);
                    hold_new_n = din;
                    hold_cnt_n = 2'd1;
                    cnt_n      = CNT_W'(1);
                end
            end else if (state == IN_FRAME) begin
                if (hold_cnt == 2'd2) begin
                    dout_vld_n = 1'b1;
                    dout_n     = hold_old;
                end
                if (din_eof) begin
                    dout_last_n   = (hold_cnt == 2'd2) && !len_err;
                    res_vld_n     = 1'b1;
                    res_ok_n      = (crc_upd == 16'h0000) && !len_err;
                    res_len_err_n = len_err;
                    res_len_n     = payload_len(cnt_inc);
                    res_crc_rx_n  = {hold_new, din};
                    state_n       = IDLE;
                    crc_n         = INIT;
                    hold_cnt_n    = 2'd0;
                    cnt_n         = '0;
                end else begin
                    crc_n      = crc_upd;
                    cnt_n      = cnt_inc;
                    hold_old_n = hold_new;
                    hold_new_n = din;
                    if (hold_cnt != 2'd2) hold_cnt_n = hold_cnt + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            crc         <= INIT;
            hold_old    <= '0;
            hold_new    <= '0;
            hold_cnt    <= 2'd0;
            cnt         <= '0;
            dout_vld    <= 1'b0;
            dout        <= '0;
            dout_last   <= 1'b0;
            res_vld     <= 1'b0;
            res_ok      <= 1'b0;
            res_len_err <= 1'b0;
            res_abort   <= 1'b0;
            res_len     <= '0;
            res_crc_rx  <= '0;
        end else begin
            state       <= state_n;
            crc         <= crc_n;
            hold_old    <= hold_old_n;
            hold_new    <= hold_new_n;
            hold_cnt    <= hold_cnt_n;
            cnt         <= cnt_n;
            dout_vld    <= dout_vld_n;
            dout        <= dout_n;
            dout_last   <= dout_last_n;
            res_vld     <= res_vld_n;
            res_ok      <= res_ok_n;
            res_len_err <= res_len_err_n;
            res_abort   <= res_abort_n;
            res_len     <= res_len_n;
            res_crc_rx  <= res_crc_rx_n;
        end
    end
endmodule

// File: tb/tb_crc_frame_checker.sv
// tb/tb_crc_frame_checker.sv - scoreboard bench for crc_frame_checker at MAX_LEN=1024 and MAX_LEN=4
module tb_crc_frame_checker;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       din_vld = 1'b0, din_sof = 1'b0, din_eof = 1'b0;
    logic [7:0] din = 8'h00;

    logic        a_dout_vld, a_dout_last, a_res_vld, a_res_ok, a_res_len_err, a_res_abort;
    logic [7:0]  a_dout;
    logic [10:0] a_res_len;
    logic [15:0] a_res_crc_rx;
    logic        b_dout_vld, b_dout_last, b_res_vld, b_res_ok, b_res_len_err, b_res_abort;
    logic [7:0]  b_dout;
    logic [2:0]  b_res_len;
    logic [15:0] b_res_crc_rx;

    always #5 clk = ~clk;

    crc_frame_checker dut_a (
        .clk(clk), .reset(reset), .din_vld(din_vld), .din(din), .din_sof(din_sof), .din_eof(din_eof),
        .dout_vld(a_dout_vld), .dout(a_dout), .dout_last(a_dout_last), .res_vld(a_res_vld),
        .res_ok(a_res_ok), .res_len_err(a_res_len_err), .res_abort(a_res_abort),
        .res_len(a_res_len), .res_crc_rx(a_res_crc_rx)
    );

    crc_frame_checker #(.MAX_LEN(4)) dut_b (
        .clk(clk), .reset(reset), .din_vld(din_vld), .din(din), .din_sof(din_sof), .din_eof(din_eof),
        .dout_vld(b_dout_vld), .dout(b_dout), .dout_last(b_dout_last), .res_vld(b_res_vld),
        .res_ok(b_res_ok), .res_len_err(b_res_len_err), .res_abort(b_res_abort),
        .res_len(b_res_len), .res_crc_rx(b_res_crc_rx)
    );

    typedef struct { logic [7:0] b; logic last; } dexp_t;
    typedef struct {
        logic ok, len_err, abort, chk_err, chk_crc;
        int len;
        logic [15:0] crc_rx;
    } rexp_t;

    dexp_t qa_d[$], qb_d[$];
    rexp_t qa_r[$], qb_r[$];
    logic [7:0] cur[$];
    bit in_frame = 0;
    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: got output expected none at %0t", name, $time);
    endtask

    // Augmented-message polynomial division; INIT enters as x^n times the seed.
    function automatic logic [15:0] crc_of(input logic [7:0] m[$]);
        bit bits[$];
        logic [16:0] p = 17'h11021;
        logic [15:0] seed = 16'hFFFF;
        logic [15:0] r;
        foreach (m[k]) for (int i = 7; i >= 0; i--) bits.push_back(m[k][i]);
        for (int i = 0; i < 16; i++) bits.push_back(1'b0);
        for (int i = 0; i < 16; i++) bits[i] = bits[i] ^ seed[15-i];
        for (int i = 0; i + 16 < bits.size(); i++)
            if (bits[i]) for (int j = 0; j <= 16; j++) bits[i+j] = bits[i+j] ^ p[16-j];
        for (int i = 0; i < 16; i++) r[15-i] = bits[bits.size()-16+i];
        return r;
    endfunction

    function automatic int exp_len(input int pay, input int maxl);
        if (pay < 0) return 0;
        return (pay > maxl + 1) ? maxl + 1 : pay;
    endfunction

    function automatic rexp_t complete_res(input int maxl);
        rexp_t r;
        int L = cur.size();
        r.len_err = (L < 3) || (L - 2 > maxl);
        r.ok      = (crc_of(cur) == 16'h0000) && !r.len_err;
        r.abort   = 1'b0;
        r.chk_err = 1'b1;
        r.chk_crc = (L >= 2);
        r.len     = exp_len(L - 2, maxl);
        r.crc_rx  = (L >= 2) ? {cur[L-2], cur[L-1]} : 16'h0000;
        return r;
    endfunction

    function automatic rexp_t abort_res(input int maxl);
        rexp_t r;
        r.ok = 1'b0; r.len_err = 1'b0; r.abort = 1'b1; r.chk_err = 1'b0; r.chk_crc = 1'b0;
        r.len = exp_len(cur.size() - 2, maxl);
        r.crc_rx = 16'h0000;
        return r;
    endfunction

    task automatic finish_frame();
        int L = cur.size();
        if (L >= 3) begin
            qa_d.push_back('{cur[L-3], !(L - 2 > 1024)});
            qb_d.push_back('{cur[L-3], !(L - 2 > 4)});
        end
        qa_r.push_back(complete_res(1024));
        qb_r.push_back(complete_res(4));
        in_frame = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit sof, input bit eof);
        if (sof) begin
            if (in_frame) begin
                qa_r.push_back(abort_res(1024));
                qb_r.push_back(abort_res(4));
            end
            cur.delete();
            cur.push_back(b);
            in_frame = 1;
            if (eof) finish_frame();
        end else if (in_frame) begin
            cur.push_back(b);
            if (eof) finish_frame();
            else if (cur.size() >= 3) begin
                // A byte is known to be payload once two more bytes follow it.
                qa_d.push_back('{cur[cur.size()-3], 1'b0});
                qb_d.push_back('{cur[cur.size()-3], 1'b0});
            end
        end
    endtask

    task automatic put(input logic [7:0] b, input bit sof, input bit eof);
        model_byte(b, sof, eof);
        @(negedge clk);
        din_vld = 1'b1; din = b; din_sof = sof; din_eof = eof;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_vld = 1'b0; din_sof = 1'b0; din_eof = 1'b0; din = 8'($urandom);
        end
    endtask

    task automatic send_frame(input logic [7:0] f[$], input int upto, input int gmax);
        for (int i = 0; i < upto; i++) begin
            idle($urandom_range(0, gmax));
            put(f[i], i == 0, i == f.size() - 1);
        end
    endtask

    task automatic mk_frame(input int n, input bit corrupt, output logic [7:0] f[$]);
        logic [15:0] c;
        f.delete();
        for (int i = 0; i < n; i++) f.push_back(8'($urandom));
        c = crc_of(f);
        f.push_back(c[15:8]);
        f.push_back(c[7:0] ^ {7'd0, corrupt});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; din_vld = 1'b0; din_sof = 1'b0; din_eof = 1'b0;
        cur.delete();
        in_frame = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    always @(negedge clk) if (!reset) begin
        dexp_t d; rexp_t r;
        if (a_dout_vld) begin
            if (qa_d.size() == 0) unexpected("a_dout");
            else begin
                d = qa_d.pop_front();
                chk("a_dout", 32'(a_dout), 32'(d.b));
                chk("a_dout_last", 32'(a_dout_last), 32'(d.last));
            end
        end
        if (a_res_vld) begin
            if (qa_r.size() == 0) unexpected("a_res");
            else begin
                r = qa_r.pop_front();
                chk("a_res_ok", 32'(a_res_ok), 32'(r.ok));
                chk("a_res_abort", 32'(a_res_abort), 32'(r.abort));
                chk("a_res_len", 32'(a_res_len), 32'(r.len));
                if (r.chk_err) chk("a_res_len_err", 32'(a_res_len_err), 32'(r.len_err));
                if (r.chk_crc) chk("a_res_crc_rx", 32'(a_res_crc_rx), 32'(r.crc_rx));
            end
        end
    end

    always @(negedge clk) if (!reset) begin
        dexp_t d; rexp_t r;
        if (b_dout_vld) begin
            if (qb_d.size() == 0) unexpected("b_dout");
            else begin
                d = qb_d.pop_front();
                chk("b_dout", 32'(b_dout), 32'(d.b));
                chk("b_dout_last", 32'(b_dout_last), 32'(d.last));
            end
        end
        if (b_res_vld) begin
            if (qb_r.size() == 0) unexpected("b_res");
            else begin
                r = qb_r.pop_front();
                chk("b_res_ok", 32'(b_res_ok), 32'(r.ok));
                chk("b_res_abort", 32'(b_res_abort), 32'(r.abort));
                chk("b_res_len", 32'(b_res_len), 32'(r.len));
                if (r.chk_err) chk("b_res_len_err", 32'(b_res_len_err), 32'(r.len_err));
                if (r.chk_crc) chk("b_res_crc_rx", 32'(b_res_crc_rx), 32'(r.crc_rx));
            end
        end
    end

    initial begin
        logic [7:0] t1[$];
        logic [7:0] t2[$];
        logic [7:0] f[$];
        int upto;
        t1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};

        repeat (3) @(negedge clk);
        chk("rst_a_outs", 32'({a_dout_vld, a_dout_last, a_res_vld, a_res_ok, a_res_len_err, a_res_abort}), 32'd0);
        chk("rst_a_data", 32'({a_dout, a_res_len, a_res_crc_rx}), 32'd0);
        chk("rst_b_outs", 32'({b_dout_vld, b_dout_last, b_res_vld, b_res_ok, b_res_len_err, b_res_abort}), 32'd0);
        chk("crc_ref_check", 32'(crc_of(t1)), 32'd0);
        reset = 1'b0;
        idle(2);

        send_frame(t1, 11, 0); idle(3);
        t2 = t1; t2[10] = 8'hB0;
        send_frame(t2, 11, 0); idle(3);
        put(8'h31, 1, 0); put(8'h32, 0, 0); put(8'h33, 0, 0);
        send_frame(t1, 11, 0); idle(3);
        put(8'h55, 1, 1); idle(2);
        put(8'h12, 1, 0); put(8'h34, 0, 1); idle(3);
        put(8'hAA, 0, 0); idle(2); put(8'hBB, 0, 1);
        send_frame(t1, 11, 5); put(8'hCC, 0, 0); idle(3);
        send_frame(t1, 5, 0); idle(3);
        do_reset();
        send_frame(t1, 11, 0); idle(3);
        mk_frame(5, 0, f); send_frame(f, f.size(), 0); idle(3);
        mk_frame(7, 0, f); send_frame(f, f.size(), 1); idle(3);
        mk_frame(8, 0, f); send_frame(f, 10, 0);
        send_frame(t1, 11, 0); idle(3);

        for (int n = 0; n < 60; n++) begin
            if (!in_frame && $urandom_range(0, 3) == 0) begin
                put(8'($urandom), 0, 1'($urandom));
                idle($urandom_range(0, 2));
            end
            mk_frame($urandom_range(0, 8), $urandom_range(0, 3) == 0, f);
            upto = ($urandom_range(0, 5) == 0) ? $urandom_range(1, f.size() - 1) : f.size();
            send_frame(f, upto, 3);
            if (upto == f.size()) idle($urandom_range(0, 3));
        end
        if (in_frame) send_frame(t1, 11, 0);
        idle(10);

        chk("a_dout_drained", 32'(qa_d.size()), 32'd0);
        chk("a_res_drained", 32'(qa_r.size()), 32'd0);
        chk("b_dout_drained", 32'(qb_d.size()), 32'd0);
        chk("b_res_drained", 32'(qb_r.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
